// File: rtl/mem_req_arbiter_if.sv
// Two-master request/response bus plus the downstream memory-controller channel.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface mem_req_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic [1:0]              m_req_valid;
    logic [1:0]              m_req_ready;
    logic [2*ADDR_WIDTH-1:0] m_req_addr;
    logic [2*DATA_WIDTH-1:0] m_req_wdata;
    logic [1:0]              m_req_write;
    logic [1:0]              m_resp_valid;
    logic [1:0]              m_resp_ready;
    logic [DATA_WIDTH-1:0]   m_resp_rdata;
    logic                    m_resp_error;

    logic                    mem_req_valid;
    logic                    mem_req_ready;
    logic [ADDR_WIDTH-1:0]   mem_req_addr;
    logic [DATA_WIDTH-1:0]   mem_req_wdata;
    logic                    mem_req_write;
    logic                    mem_resp_valid;
    logic                    mem_resp_ready;
    logic [DATA_WIDTH-1:0]   mem_resp_rdata;
    logic                    mem_resp_error;

    modport slave (
        input  m_req_valid, m_req_addr, m_req_wdata, m_req_write, m_resp_ready,
        output m_req_ready, m_resp_valid, m_resp_rdata, m_resp_error,
        output mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_write, mem_resp_ready,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_error
    );

    modport master (
        output m_req_valid, m_req_addr, m_req_wdata, m_req_write, m_resp_ready,
        input  m_req_ready, m_resp_valid, m_resp_rdata, m_resp_error,
        input  mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_write, mem_resp_ready,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_error
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter for two masters sharing one memory controller; an owner FIFO
// records which master issued each accepted request so in-order responses route back.
module mem_req_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int TAG_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    mem_req_arbiter_if.slave               bus,
    output logic [$clog2(TAG_DEPTH+1)-1:0] outstanding,
    output logic                           err_orphan
);
    localparam int CNT_W = $clog2(TAG_DEPTH + 1);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAG_DEPTH);

    logic             last_grant;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             owner [TAG_DEPTH];

    logic       any_req;
    logic       grant_idx;
    logic [1:0] grant;
    logic       full;
    logic       empty;
    logic       accept;
    logic       pop;
    logic       head;

    // Grant is recomputed every cycle; nothing is locked until the memory side accepts.
    always_comb begin
        any_req   = |bus.m_req_valid;
        grant_idx = 1'b0;
        if (bus.m_req_valid == 2'b11)
            grant_idx = ~last_grant;
        else
            grant_idx = bus.m_req_valid[1];
        grant = 2'b00;
        if (any_req)
            grant = grant_idx ? 2'b10 : 2'b01;
    end

    assign full  = (outstanding == FULL_CNT);
    assign empty = (outstanding == '0);

    assign bus.mem_req_valid = any_req && !full;
    assign bus.mem_req_addr  = grant_idx ? bus.m_req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                         : bus.m_req_addr[ADDR_WIDTH-1:0];
    assign bus.mem_req_wdata = grant_idx ? bus.m_req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                         : bus.m_req_wdata[DATA_WIDTH-1:0];
    assign bus.mem_req_write = bus.m_req_write[grant_idx];
    assign bus.m_req_ready   = grant & {2{bus.mem_req_ready && !full}};
    assign accept            = bus.mem_req_valid && bus.mem_req_ready;

    // With no owner on record the beat is an orphan: accept and drop it.
    assign head               = owner[rd_ptr];
    assign bus.m_resp_valid   = empty ? 2'b00
                              : (head ? {bus.mem_resp_valid, 1'b0} : {1'b0, bus.mem_resp_valid});
    assign bus.mem_resp_ready = empty ? 1'b1 : bus.m_resp_ready[head];
    assign pop                = bus.mem_resp_valid && bus.mem_resp_ready && !empty;

    assign bus.m_resp_rdata = bus.mem_resp_rdata;
    assign bus.m_resp_error = bus.mem_resp_error;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant  <= 1'b1;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            err_orphan  <= 1'b0;
        end else begin
            if (accept) begin
                last_grant <= grant_idx;
                wr_ptr     <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (accept && !pop)
                outstanding <= outstanding + 1'b1;
            else if (!accept && pop)
                outstanding <= outstanding - 1'b1;
            if (bus.mem_resp_valid && empty)
                err_orphan <= 1'b1;
        end
    end

    // Owner storage is qualified by the pointers, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept)
            owner[wr_ptr] <= grant_idx;
    end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed scenarios with literal expectations
// followed by randomized traffic compared every cycle against a queue-based model.
module tb_mem_req_arbiter;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int TAG_DEPTH = 4;
    localparam int CW = $clog2(TAG_DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] outstanding;
    logic          err_orphan;

    mem_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_DEPTH(TAG_DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .outstanding (outstanding),
        .err_orphan  (err_orphan)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: queue of owning master indices, round-robin pointer, sticky orphan flag.
    int unsigned mq[$];
    int          m_last;
    bit          m_err;

    logic [1:0]    s_m_req_ready;
    logic          s_mem_req_valid;
    logic [AW-1:0] s_mem_req_addr;
    logic          s_mem_req_write;
    logic [1:0]    s_m_resp_valid;
    logic          s_mem_resp_ready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_last = 1;
        m_err  = 1'b0;
    endtask

    task automatic idle();
        bus.m_req_valid    = 2'b00;
        bus.m_req_addr     = '0;
        bus.m_req_wdata    = '0;
        bus.m_req_write    = 2'b00;
        bus.m_resp_ready   = 2'b00;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = '0;
        bus.mem_resp_error = 1'b0;
    endtask

    // Compare all DUT outputs for the current cycle's inputs, then advance the model.
    task automatic check_cycle();
        logic [1:0] mv;
        int         g;
        int         head;
        bit         full;
        bit         emp;
        bit         acc;
        bit         pop;
        logic       e_mv;
        logic [1:0] e_mrr;
        logic [1:0] e_rv;
        logic       e_rr;
        mv   = bus.m_req_valid;
        full = (mq.size() == TAG_DEPTH);
        emp  = (mq.size() == 0);
        if (mv == 2'b11) g = (m_last + 1) % 2;
        else             g = mv[1] ? 1 : 0;
        e_mv  = (mv != 2'b00) && !full;
        e_mrr = 2'b00;
        if (e_mv && bus.mem_req_ready) e_mrr[g] = 1'b1;
        if (emp) begin
            e_rv = 2'b00;
            e_rr = 1'b1;
        end else begin
            head = mq[0];
            e_rr = bus.m_resp_ready[head];
            e_rv = 2'b00;
            if (bus.mem_resp_valid) e_rv[head] = 1'b1;
        end

        chk("outstanding", 64'(outstanding), 64'(mq.size()));
        chk("err_orphan", 64'(err_orphan), 64'(m_err));
        chk("mem_req_valid", 64'(bus.mem_req_valid), 64'(e_mv));
        chk("m_req_ready", 64'(bus.m_req_ready), 64'(e_mrr));
        if (e_mv) begin
            chk("mem_req_addr", 64'(bus.mem_req_addr),
                64'(g ? bus.m_req_addr[2*AW-1:AW] : bus.m_req_addr[AW-1:0]));
            chk("mem_req_wdata", bus.mem_req_wdata,
                g ? bus.m_req_wdata[2*DW-1:DW] : bus.m_req_wdata[DW-1:0]);
            chk("mem_req_write", 64'(bus.mem_req_write), 64'(bus.m_req_write[g]));
        end
        chk("m_resp_valid", 64'(bus.m_resp_valid), 64'(e_rv));
        chk("mem_resp_ready", 64'(bus.mem_resp_ready), 64'(e_rr));
        chk("m_resp_rdata", bus.m_resp_rdata, bus.mem_resp_rdata);
        chk("m_resp_error", 64'(bus.m_resp_error), 64'(bus.mem_resp_error));

        s_m_req_ready    = bus.m_req_ready;
        s_mem_req_valid  = bus.mem_req_valid;
        s_mem_req_addr   = bus.mem_req_addr;
        s_mem_req_write  = bus.mem_req_write;
        s_m_resp_valid   = bus.m_resp_valid;
        s_mem_resp_ready = bus.mem_resp_ready;

        acc = e_mv && bus.mem_req_ready;
        pop = !emp && bus.mem_resp_valid && e_rr;
        if (emp && bus.mem_resp_valid) m_err = 1'b1;
        if (pop) void'(mq.pop_front());
        if (acc) begin
            mq.push_back(g);
            m_last = g;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_err_orphan", 64'(err_orphan), 64'd0);
        chk("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
        chk("rst_m_resp_valid", 64'(bus.m_resp_valid), 64'd0);
        chk("rst_m_req_ready", 64'(bus.m_req_ready), 64'd0);
        rst_n = 1'b1;

        // Both masters pending, no responses: alternate grants, then stall at full.
        bus.m_req_valid   = 2'b11;
        bus.mem_req_ready = 1'b1;
        bus.m_req_addr    = {32'h0000_1111, 32'h0000_0000};
        tick(); chk("rr_grant1", 64'(s_m_req_ready), 64'h1);
        tick(); chk("rr_grant2", 64'(s_m_req_ready), 64'h2);
        tick(); chk("rr_grant3", 64'(s_m_req_ready), 64'h1);
        tick(); chk("rr_grant4", 64'(s_m_req_ready), 64'h2);
        chk("full_outstanding", 64'(outstanding), 64'd4);
        tick();
        chk("full_m_req_ready", 64'(s_m_req_ready), 64'h0);
        chk("full_mem_req_valid", 64'(s_mem_req_valid), 64'h0);

        // Pop and request together while full: request blocked this cycle only.
        bus.mem_resp_valid = 1'b1;
        bus.m_resp_ready   = 2'b11;
        tick();
        chk("full_pop_blocked", 64'(s_m_req_ready), 64'h0);
        chk("full_pop_outstanding", 64'(outstanding), 64'd3);
        bus.mem_resp_valid = 1'b0;
        tick();
        chk("refill_grant", 64'(s_m_req_ready), 64'h1);
        chk("refill_outstanding", 64'(outstanding), 64'd4);

        bus.m_req_valid    = 2'b00;
        bus.mem_resp_valid = 1'b1;
        repeat (4) tick();
        chk("drained", 64'(outstanding), 64'd0);
        bus.mem_resp_valid = 1'b0;

        // Master 1 reads 0x10, then master 0 writes; responses return in that order.
        bus.m_req_valid = 2'b10;
        bus.m_req_addr  = {32'h0000_0010, 32'h0000_0020};
        bus.m_req_write = 2'b01;
        tick();
        chk("m1_read_ready", 64'(s_m_req_ready), 64'h2);
        chk("m1_read_addr", 64'(s_mem_req_addr), 64'h10);
        chk("m1_read_write", 64'(s_mem_req_write), 64'h0);
        bus.m_req_valid = 2'b01;
        tick();
        chk("m0_write_ready", 64'(s_m_req_ready), 64'h1);
        chk("m0_write_write", 64'(s_mem_req_write), 64'h1);
        bus.m_req_valid    = 2'b00;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = 64'hDEAD_BEEF_0000_0001;
        tick();
        chk("resp1_route", 64'(s_m_resp_valid), 64'h2);
        bus.mem_resp_rdata = 64'hDEAD_BEEF_0000_0002;
        tick();
        chk("resp2_route", 64'(s_m_resp_valid), 64'h1);

        // Orphan response with nothing outstanding.
        chk("pre_orphan_err", 64'(err_orphan), 64'd0);
        tick();
        chk("orphan_ready", 64'(s_mem_resp_ready), 64'h1);
        chk("orphan_route", 64'(s_m_resp_valid), 64'h0);
        chk("orphan_set", 64'(err_orphan), 64'd1);
        bus.mem_resp_valid = 1'b0;
        tick();
        chk("orphan_sticky", 64'(err_orphan), 64'd1);

        for (int i = 0; i < 1500; i++) begin
            bus.m_req_valid    = 2'($urandom_range(0, 3));
            bus.m_req_addr     = {$urandom(), $urandom()};
            bus.m_req_wdata    = {$urandom(), $urandom(), $urandom(), $urandom()};
            bus.m_req_write    = 2'($urandom_range(0, 3));
            bus.mem_req_ready  = ($urandom_range(0, 3) != 0);
            bus.mem_resp_valid = ($urandom_range(0, 9) < 4);
            bus.m_resp_ready   = 2'($urandom_range(0, 3));
            bus.mem_resp_rdata = {$urandom(), $urandom()};
            bus.mem_resp_error = 1'($urandom_range(0, 1));
            tick();
        end

        // Reset with two requests in flight.
        idle();
        bus.mem_resp_valid = 1'b1;
        bus.m_resp_ready   = 2'b11;
        for (int i = 0; i < 12 && outstanding != 0; i++) tick();
        chk("pre_reset_drain", 64'(outstanding), 64'd0);
        idle();
        bus.m_req_valid   = 2'b01;
        bus.mem_req_ready = 1'b1;
        repeat (2) tick();
        chk("pre_reset_outstanding", 64'(outstanding), 64'd2);
        idle();
        rst_n = 1'b0;
        #1;
        chk("async_rst_outstanding", 64'(outstanding), 64'd0);
        chk("async_rst_err_orphan", 64'(err_orphan), 64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.m_req_valid   = 2'b11;
        bus.mem_req_ready = 1'b1;
        tick();
        chk("post_reset_grant", 64'(s_m_req_ready), 64'h1);
        idle();
        bus.mem_resp_valid = 1'b1;
        bus.m_resp_ready   = 2'b11;
        repeat (2) tick();
        chk("post_reset_orphan", 64'(err_orphan), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, request address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, write/read data width.
REQ-003 SHALL have parameter TAG_DEPTH, default 4, max outstanding requests (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port m_req_valid  input  2  per-master request valid; bit i = master i.
REQ-007 SHALL have port m_req_ready  output  2  per-master request accepted.
REQ-008 SHALL have port m_req_addr  input  2*ADDR_WIDTH  packed addresses; master i at [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 SHALL have port m_req_wdata  input  2*DATA_WIDTH  packed write data, same packing.
REQ-010 SHALL have port m_req_write  input  2  per-master write flag (1=write, 0=read).
REQ-011 SHALL have port m_resp_valid  output  2  per-master response valid.
REQ-012 SHALL have port m_resp_ready  input  2  per-master response ready.
REQ-013 SHALL have port m_resp_rdata  output  DATA_WIDTH  response data, broadcast to both masters.
REQ-014 SHALL have port m_resp_error  output  1  response error, broadcast.
REQ-015 SHALL have port mem_req_valid / mem_req_ready / mem_req_addr / mem_req_wdata / mem_req_write  out/in/out/out/out  1/1/ADDR_WIDTH/DATA_WIDTH/1  downstream memory-controller request channel.
REQ-016 SHALL have port mem_resp_valid / mem_resp_ready / mem_resp_rdata / mem_resp_error  in/out/in/in  1/1/DATA_WIDTH/1  downstream response channel.
REQ-017 SHALL have port outstanding  output  $clog2(TAG_DEPTH+1)  number of accepted, unanswered requests.
REQ-018 SHALL have port err_orphan  output  1  sticky flag: response arrived with no outstanding request.

Function
REQ-019 SHALL arbitrate round-robin: priority goes to the master after last_grant; last_grant updates only on a downstream accept.
REQ-020 SHALL compute grant combinationally each cycle from m_req_valid and last_grant; no grant lock before acceptance.
REQ-021 SHALL drive mem_req_valid = (|m_req_valid) && !full, with addr/wdata/write muxed from the granted master.
REQ-022 SHALL drive m_req_ready[i] = grant[i] && mem_req_ready && !full; the non-granted bit SHALL be 0.
REQ-023 SHALL, on accept (mem_req_valid && mem_req_ready), push the granted index into an owner FIFO of depth TAG_DEPTH, in the same cycle, with zero added latency.
REQ-024 SHALL treat full (outstanding == TAG_DEPTH) as blocking acceptance, even if a pop occurs in the same cycle.
REQ-025 SHALL route responses in order: m_resp_valid[head] = mem_resp_valid, the other bit 0; mem_resp_ready = m_resp_ready[head] when the FIFO is non-empty.
REQ-026 SHALL pop the FIFO head on mem_resp_valid && mem_resp_ready.
REQ-027 SHALL handle simultaneous push and pop by leaving outstanding unchanged and wrapping the pointers modulo TAG_DEPTH.
REQ-028 SHALL, when mem_resp_valid is asserted with the FIFO empty, drive mem_resp_ready=1, drop the beat, and set err_orphan until reset.
REQ-029 SHALL pass m_resp_rdata/m_resp_error straight from mem_resp_rdata/mem_resp_error, combinationally.

Reset
REQ-030 SHALL, while rst_n=0, force FIFO empty, outstanding=0, err_orphan=0, last_grant=1 (master 0 wins first), and pointers=0.
REQ-031 SHALL, after reset, hold all outputs derived from the empty FIFO at 0: m_resp_valid=0, mem_req_valid=0 with no request.
REQ-032 SHALL discard in-flight ownership on reset mid-operation; responses after reset SHALL count as orphans.

Verification
REQ-033 Both masters valid continuously, mem_req_ready=1 -> grants alternate 0,1,0,1; first grant = master 0.
REQ-034 Master 1 issues a read to addr 0x10, then master 0 issues a write; two responses arrive -> first goes to m_resp_valid[1], second to m_resp_valid[0].
REQ-035 TAG_DEPTH=4, responses withheld -> 4 requests accepted, outstanding=4, mem_req_valid=0, m_req_ready=0 on the fifth.
REQ-036 Full FIFO with a response popping and a new request in the same cycle -> request not accepted that cycle; accepted the next cycle; outstanding 4->3->4.
REQ-037 mem_resp_valid=1 with outstanding=0 -> mem_resp_ready=1, m_resp_valid=00, err_orphan=1 and stays set.
REQ-038 rst_n asserted with outstanding=2 -> outstanding=0 and err_orphan=0 immediately; the next grant goes to master 0.
